// File: rtl/digit_overlay_pipe_pkg.sv
// Shared constants and helpers for the digit overlay pipeline.
// Holds font geometry, character codes, colour codes and the BCD-to-ASCII mapping.
package overlay_pkg;

    localparam int FONT_W = 8;
    localparam int FONT_H = 16;

    localparam logic [6:0] CHAR_DIGIT_BASE = 7'h30;
    localparam logic [6:0] CHAR_INVALID    = 7'h3F;
    localparam logic [6:0] CHAR_COLON      = 7'h3A;

    localparam logic [3:0] COLOR_OFF      = 4'd0;
    localparam logic [3:0] COLOR_NORM_DEF = 4'd2;
    localparam logic [3:0] COLOR_EDIT_DEF = 4'd4;

    function automatic int fsel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Nibbles above 9 are not BCD and render as '?'.
    function automatic logic [6:0] bcd_to_char(input logic [3:0] d);
        logic [6:0] c;
        if (d <= 4'd9) begin
            c = CHAR_DIGIT_BASE + {3'b000, d};
        end else begin
            c = CHAR_INVALID;
        end
        return c;
    endfunction

endpackage

// File: rtl/digit_overlay_pipe_if.sv
// Pixel-in / font-and-colour-out bundle between the sync generator side and the overlay.
// master = pixel source / ROM consumer, slave = the overlay pipeline.
interface digit_overlay_pipe_if
    import overlay_pkg::*;
#(
    parameter int N_FIELDS = 3,
    parameter int FSEL_W   = fsel_width(N_FIELDS)
) ();

    logic [9:0]            pixelx;
    logic [9:0]            pixely;
    logic                  video_on;
    logic                  frame_tick;
    logic [8*N_FIELDS-1:0] digits;
    logic                  edit_en;
    logic [FSEL_W-1:0]     edit_sel;
    logic [10:0]           rom_addr;
    logic [2:0]            bit_col;
    logic [3:0]            color_addr;
    logic                  char_on;

    modport master (
        output pixelx, pixely, video_on, frame_tick, digits, edit_en, edit_sel,
        input  rom_addr, bit_col, color_addr, char_on
    );

    modport slave (
        input  pixelx, pixely, video_on, frame_tick, digits, edit_en, edit_sel,
        output rom_addr, bit_col, color_addr, char_on
    );

endinterface

// File: rtl/digit_overlay_pipe_blink_timer.sv
// Frame-synchronous blink phase: toggles every BLINK_FRAMES frame_tick pulses.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick,
    output logic phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // Frame counter and phase toggle on terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (frame_tick) begin
            if (r_cnt == TERM) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt   <= r_cnt;
            r_phase <= r_phase;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/digit_overlay_pipe.sv
// Two-stage text overlay: maps the pixel onto N two-digit BCD fields, emits the font ROM
// address at T+1 and the ROM-aligned column / char_on / colour at T+2.
module digit_overlay_pipe
    import overlay_pkg::*;
#(
    parameter int         N_FIELDS     = 3,
    parameter int         X0           = 100,
    parameter int         Y0           = 3,
    parameter int         FIELD_PITCH  = 100,
    parameter int         SCALE_LOG2   = 0,
    parameter int         SEP_EN       = 1,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [3:0] COLOR_NORM   = COLOR_NORM_DEF,
    parameter logic [3:0] COLOR_EDIT   = COLOR_EDIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    digit_overlay_pipe_if.slave  bus
);

    localparam int FSEL_W = fsel_width(N_FIELDS);
    localparam int CELL_W = FONT_W << SCALE_LOG2;
    localparam int CELL_H = FONT_H << SCALE_LOG2;
    localparam logic [11:0] ROW_LO = 12'(Y0);
    localparam logic [11:0] ROW_HI = 12'(Y0 + CELL_H);

    logic [11:0]         w_px;
    logic [11:0]         w_py;
    logic [11:0]         w_dy;
    logic                w_row_hit;
    logic [3:0]          w_font_row;
    logic                w_phase;

    logic [N_FIELDS-1:0] w_fhit;
    logic [N_FIELDS-1:0] w_fcolon;
    logic [N_FIELDS-1:0] w_sel;
    logic [6:0]          w_fchar [N_FIELDS];
    logic [2:0]          w_fcol  [N_FIELDS];

    logic                w_hit;
    logic                w_is_colon;
    logic [FSEL_W-1:0]   w_field;
    logic [2:0]          w_col;
    logic [6:0]          w_char;
    logic                w_edit_match;
    logic                w_show;

    logic [10:0]         r_rom_addr;
    logic                r_s1_on;
    logic [2:0]          r_s1_col;
    logic [3:0]          r_s1_color;
    logic                r_char_on;
    logic [2:0]          r_bit_col;
    logic [3:0]          r_color;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (bus.frame_tick),
        .phase      (w_phase)
    );

    // Widened to 12 bits so offsets below an origin never alias into a cell.
    assign w_px       = {2'b00, bus.pixelx};
    assign w_py       = {2'b00, bus.pixely};
    assign w_dy       = w_py - ROW_LO;
    assign w_row_hit  = (w_py >= ROW_LO) && (w_py < ROW_HI);
    assign w_font_row = 4'(w_dy >> SCALE_LOG2);

    for (genvar g = 0; g < N_FIELDS; g++) begin : g_field
        localparam logic [11:0] XF = 12'(X0 + g * FIELD_PITCH);
        localparam bit HAS_COLON = (SEP_EN != 0) && (g < N_FIELDS - 1);

        logic [11:0] w_dx;
        logic [11:0] w_cell_dx;
        logic        w_in;
        logic        w_tens;
        logic        w_units;
        logic        w_colon;

        assign w_dx    = w_px - XF;
        assign w_in    = bus.video_on && w_row_hit && (w_px >= XF);
        assign w_tens  = w_in && (w_dx < 12'(CELL_W));
        assign w_units = w_in && (w_dx >= 12'(CELL_W)) && (w_dx < 12'(2 * CELL_W));
        assign w_colon = w_in && HAS_COLON && (w_dx >= 12'(2 * CELL_W)) && (w_dx < 12'(3 * CELL_W));

        assign w_cell_dx   = w_tens  ? w_dx :
                             w_units ? (w_dx - 12'(CELL_W)) : (w_dx - 12'(2 * CELL_W));
        assign w_fhit[g]   = w_tens | w_units | w_colon;
        assign w_fcolon[g] = ~w_tens & ~w_units;
        assign w_fcol[g]   = 3'(w_cell_dx >> SCALE_LOG2);
        assign w_fchar[g]  = w_tens  ? bcd_to_char(bus.digits[8*g+4 +: 4]) :
                             w_units ? bcd_to_char(bus.digits[8*g   +: 4]) : CHAR_COLON;
    end

    // Lowest set bit of the hit vector is the winning field.
    assign w_sel = w_fhit & (~w_fhit + N_FIELDS'(1));

    // One-hot select of the winning field's character, column and kind.
    always_comb begin
        w_hit      = |w_fhit;
        w_is_colon = 1'b0;
        w_field    = '0;
        w_col      = 3'd0;
        w_char     = 7'd0;
        for (int f = 0; f < N_FIELDS; f++) begin
            w_is_colon = w_is_colon | (w_sel[f] & w_fcolon[f]);
            w_field    = w_field | ({FSEL_W{w_sel[f]}} & FSEL_W'(f));
            w_col      = w_col   | ({3{w_sel[f]}} & w_fcol[f]);
            w_char     = w_char  | ({7{w_sel[f]}} & w_fchar[f]);
        end
    end

    assign w_edit_match = bus.edit_en && (w_field == bus.edit_sel);
    assign w_show       = w_hit && !(w_edit_match && w_phase && !w_is_colon);

    // Stage 1: ROM address plus the attributes that must wait for ROM data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= 11'd0;
            r_s1_on    <= 1'b0;
            r_s1_col   <= 3'd0;
            r_s1_color <= COLOR_OFF;
        end else begin
            r_rom_addr <= w_hit  ? {w_char, w_font_row} : 11'd0;
            r_s1_on    <= w_show;
            r_s1_col   <= w_hit  ? w_col : 3'd0;
            r_s1_color <= w_show ? (w_edit_match ? COLOR_EDIT : COLOR_NORM) : COLOR_OFF;
        end
    end

    // Stage 2: aligned with the font ROM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_char_on <= 1'b0;
            r_bit_col <= 3'd0;
            r_color   <= COLOR_OFF;
        end else begin
            r_char_on <= r_s1_on;
            r_bit_col <= r_s1_col;
            r_color   <= r_s1_color;
        end
    end

    assign bus.rom_addr   = r_rom_addr;
    assign bus.char_on    = r_char_on;
    assign bus.bit_col    = r_bit_col;
    assign bus.color_addr = r_color;

endmodule

// File: tb/tb_digit_overlay_pipe.sv
// Scoreboard bench: stimulus queues expected T+2 responses, a negedge monitor pops and compares.
// dut_a uses BLINK_FRAMES=2, dut_b uses SCALE_LOG2=1; all other parameters at defaults.
module tb_digit_overlay_pipe;
    import overlay_pkg::*;

    typedef struct {
        int         due;
        bit         on_b;
        logic [10:0] rom;
        logic       on;
        logic [3:0] color;
        logic [2:0] bitc;
        bit         chk_bitc;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [10:0] rom_d_a = 11'd0;
    logic [10:0] rom_d_b = 11'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digit_overlay_pipe_if #(.N_FIELDS(3)) ifa ();
    digit_overlay_pipe_if #(.N_FIELDS(3)) ifb ();

    digit_overlay_pipe #(.N_FIELDS(3), .BLINK_FRAMES(2)) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(ifa.slave)
    );
    digit_overlay_pipe #(.N_FIELDS(3), .SCALE_LOG2(1)) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(ifb.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_pix(input int x, input int y);
        ifa.pixelx = 10'(x); ifa.pixely = 10'(y);
        ifb.pixelx = 10'(x); ifb.pixely = 10'(y);
    endtask

    task automatic set_edit(input bit en, input logic [1:0] sel);
        ifa.edit_en = en; ifa.edit_sel = sel;
        ifb.edit_en = en; ifb.edit_sel = sel;
    endtask

    task automatic set_video(input bit v);
        ifa.video_on = v; ifb.video_on = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic tick();
        ifa.frame_tick = 1'b1; ifb.frame_tick = 1'b1;
        @(posedge clk); #1;
        ifa.frame_tick = 1'b0; ifb.frame_tick = 1'b0;
    endtask

    // Present one pixel for one clock and queue the response expected two clocks later.
    task automatic apply(input int x, input int y, input bit on_b, input logic [10:0] rom,
                         input logic on, input logic [3:0] color, input logic [2:0] bitc,
                         input bit chk_bitc, input string name);
        exp_t e;
        set_pix(x, y);
        e.due = cyc + 2; e.on_b = on_b; e.rom = rom; e.on = on; e.color = color;
        e.bitc = bitc; e.chk_bitc = chk_bitc; e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    // Monitor: rom_addr is compared one cycle earlier than the stage-2 outputs.
    initial begin
        exp_t e;
        logic [10:0] r;
        logic        o;
        logic [3:0]  c;
        logic [2:0]  b;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due != cyc) begin
                    check({e.name, ".late"}, 32'(cyc), 32'(e.due));
                end else begin
                    r = e.on_b ? rom_d_b        : rom_d_a;
                    o = e.on_b ? ifb.char_on    : ifa.char_on;
                    c = e.on_b ? ifb.color_addr : ifa.color_addr;
                    b = e.on_b ? ifb.bit_col    : ifa.bit_col;
                    check({e.name, ".rom_addr"},   32'(r), 32'(e.rom));
                    check({e.name, ".char_on"},    32'(o), 32'(e.on));
                    check({e.name, ".color_addr"}, 32'(c), 32'(e.color));
                    if (e.chk_bitc) check({e.name, ".bit_col"}, 32'(b), 32'(e.bitc));
                end
            end
            rom_d_a = ifa.rom_addr;
            rom_d_b = ifb.rom_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_pix(0, 0);
        set_video(1'b1);
        ifa.frame_tick = 1'b0; ifb.frame_tick = 1'b0;
        ifa.digits = 24'h00A245; ifb.digits = 24'h00A245;
        set_edit(1'b0, 2'd0);
        idle(2);
        check("reset.rom_addr",   32'(ifa.rom_addr),   32'd0);
        check("reset.char_on",    32'(ifa.char_on),    32'd0);
        check("reset.bit_col",    32'(ifa.bit_col),    32'd0);
        check("reset.color_addr", 32'(ifa.color_addr), 32'd0);
        rst_n = 1'b1;

        apply(100,  3, 1'b0, 11'h340, 1'b1, 4'd2, 3'd0, 1'b1, "t1_tens");
        apply(109, 10, 1'b0, 11'h357, 1'b1, 4'd2, 3'd1, 1'b1, "t2_units");
        apply(116,  3, 1'b0, 11'h3A0, 1'b1, 4'd2, 3'd0, 1'b1, "t2_colon");
        apply(299,  3, 1'b0, 11'h000, 1'b0, 4'd0, 3'd0, 1'b0, "t2_gap");
        apply(200,  0, 1'b0, 11'h000, 1'b0, 4'd0, 3'd0, 1'b0, "t3_above");
        apply(200,  4, 1'b0, 11'h3F1, 1'b1, 4'd2, 3'd0, 1'b1, "t3_invalid");
        apply(307, 18, 1'b0, 11'h30F, 1'b1, 4'd2, 3'd7, 1'b1, "last_row_col");
        apply(307, 19, 1'b0, 11'h000, 1'b0, 4'd0, 3'd0, 1'b0, "below_cell");
        set_video(1'b0);
        apply(100,  3, 1'b0, 11'h000, 1'b0, 4'd0, 3'd0, 1'b0, "blanking");
        set_video(1'b1);
        apply(117,  5, 1'b1, 11'h351, 1'b1, 4'd2, 3'd0, 1'b1, "t5_scaled");

        set_edit(1'b1, 2'd1);
        apply(208,  5, 1'b0, 11'h322, 1'b1, 4'd4, 3'd0, 1'b1, "t4_edit_vis");
        apply(100,  5, 1'b0, 11'h342, 1'b1, 4'd2, 3'd0, 1'b1, "t4_f0_a");
        tick(); tick();
        apply(208,  5, 1'b0, 11'h322, 1'b0, 4'd0, 3'd0, 1'b0, "t4_edit_hid");
        apply(100,  5, 1'b0, 11'h342, 1'b1, 4'd2, 3'd0, 1'b1, "t4_f0_b");
        apply(216,  3, 1'b0, 11'h3A0, 1'b1, 4'd4, 3'd0, 1'b1, "colon_kept");
        tick(); tick();
        apply(208,  5, 1'b0, 11'h322, 1'b1, 4'd4, 3'd0, 1'b1, "t4_edit_back");
        apply(100,  5, 1'b0, 11'h342, 1'b1, 4'd2, 3'd0, 1'b1, "t4_f0_c");

        tick(); tick();
        set_edit(1'b1, 2'd3);
        apply(208,  5, 1'b0, 11'h322, 1'b1, 4'd2, 3'd0, 1'b1, "sel_out_of_range");
        tick(); tick();

        set_edit(1'b1, 2'd1);
        tick(); tick();
        apply(208,  5, 1'b0, 11'h322, 1'b0, 4'd0, 3'd0, 1'b0, "t6_hidden");
        apply(100,  3, 1'b0, 11'h340, 1'b1, 4'd2, 3'd0, 1'b1, "t6_pre");
        idle(3);
        rst_n = 1'b0;
        #1;
        check("t6_rst.rom_addr",   32'(ifa.rom_addr),   32'd0);
        check("t6_rst.char_on",    32'(ifa.char_on),    32'd0);
        check("t6_rst.bit_col",    32'(ifa.bit_col),    32'd0);
        check("t6_rst.color_addr", 32'(ifa.color_addr), 32'd0);
        tick(); tick();
        set_pix(208, 5);
        rst_n = 1'b1;
        apply(208,  5, 1'b0, 11'h322, 1'b1, 4'd4, 3'd0, 1'b1, "t6_resume");
        idle(4);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
